// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline.
// Contents:
//   - opcode constants and the instruction-type classification
//   - ifq_entry_t : one fetched instruction with its next-PC
//   - fetch_state_e : fetch front-end state (run / drain stale responses / halted)
package mips32_pkg;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b001000;
    localparam logic [5:0] OpSw    = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001010;
    localparam logic [5:0] OpSubi  = 6'b001011;
    localparam logic [5:0] OpSlti  = 6'b001100;
    localparam logic [5:0] OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz  = 6'b001110;
    localparam logic [5:0] OpHlt   = 6'b111111;

    typedef enum logic [2:0] {
        TypeRrAlu  = 3'd0,
        TypeRmAlu  = 3'd1,
        TypeLoad   = 3'd2,
        TypeStore  = 3'd3,
        TypeBranch = 3'd4,
        TypeHalt   = 3'd5
    } instr_type_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } fetch_state_e;

    // Classify an opcode; unknown opcodes are treated as halt.
    function automatic instr_type_e instr_type(input logic [5:0] op);
        instr_type_e t;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: t = TypeRrAlu;
            OpAddi, OpSubi, OpSlti:                  t = TypeRmAlu;
            OpLw:                                    t = TypeLoad;
            OpSw:                                    t = TypeStore;
            OpBneqz, OpBeqz:                         t = TypeBranch;
            default:                                 t = TypeHalt;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with synchronous clear.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : synchronous flush (drops contents, ignores same-cycle push)
//   push, push_data : write one entry (caller must not push when full without popping)
//   pop             : consume head entry (ignored when empty)
//   head_data       : entry at the head
//   count           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module mips32_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_en, pop_en;

    always_comb begin
        pop_en  = pop && (count_q != '0);
        push_en = push && ((count_q != CntW'(DEPTH)) || pop_en);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !rst && !clr) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mips32_ifetch_queue.sv
// Instruction fetch front end: issues word-addressed reads, buffers returned words with their
// NPC in a prefetch queue and hands IR/NPC pairs to decode. Branch redirects flush the queue
// and discard responses still in flight.
// Ports:
//   clk1, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   : read request to instruction memory (addr = PC low bits)
//   imem_rsp_valid, imem_rsp_data     : in-order read responses
//   if_id_valid/ready, if_id_ir/npc   : instruction handoff to decode
//   br_taken, br_target               : one-cycle redirect pulse and word target
//   halt                              : level, stops new fetches
// Build option: define IFQ_BYPASS_EN to forward a response straight to decode when the queue
// is empty, saving one cycle of fetch latency.
module mips32_ifetch_queue
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] PC_RESET = 32'd0
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              if_id_valid,
    input  logic              if_id_ready,
    output logic [31:0]       if_id_ir,
    output logic [31:0]       if_id_npc,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              halt
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] drop_q, drop_d;

    // The tag queue holds the address of every request in flight, so its count is the
    // outstanding-request counter.
    logic [CntW-1:0] iq_count, tag_count;
    logic [CntW:0]   credit_used;
    ifq_entry_t      iq_head, rsp_entry, out_entry;
    logic [31:0]     tag_head;
    logic            iq_empty, req_fire, rsp_keep, bypass, iq_push, iq_pop;

    always_comb begin
        iq_empty    = (iq_count == '0);
        credit_used = {1'b0, iq_count} + {1'b0, tag_count};

        imem_req_valid = !rst && (state_q == StRun) && !halt && !br_taken &&
                         (credit_used < (CntW + 1)'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_entry.ir  = imem_rsp_data;
        rsp_entry.npc = tag_head + 32'd1;
        rsp_keep      = imem_rsp_valid && !br_taken && (drop_q == '0);

`ifdef IFQ_BYPASS_EN
        bypass = !rst && iq_empty && rsp_keep;
`else
        bypass = 1'b0;
`endif

        if_id_valid = !rst && !br_taken && (!iq_empty || bypass);
        if (rst)          out_entry = '0;
        else if (bypass)  out_entry = rsp_entry;
        else if (iq_empty) out_entry = '0;
        else              out_entry = iq_head;
        if_id_ir  = out_entry.ir;
        if_id_npc = out_entry.npc;

        iq_pop  = if_id_valid && if_id_ready && !bypass;
        // A bypassed word that decode takes right away never enters the queue.
        iq_push = rsp_keep && !(bypass && if_id_ready);
    end

    assign imem_addr = pc_q[ADDR_W-1:0];

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        state_d = state_q;

        if (br_taken) begin
            pc_d   = br_target;
            drop_d = tag_count - CntW'(imem_rsp_valid && (tag_count != '0));
        end else begin
            if (req_fire) pc_d = pc_q + 32'd1;
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
        end

        unique case (state_q)
            StRun: begin
                if (br_taken)  state_d = (drop_d != '0) ? StDrain : StRun;
                else if (halt) state_d = StHalt;
            end
            StDrain: begin
                if (br_taken)            state_d = (drop_d != '0) ? StDrain : StRun;
                else if (drop_d == '0)   state_d = StRun;
            end
            StHalt: begin
                if (!br_taken && !halt) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= PC_RESET;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    mips32_sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_iq (
        .clk       (clk1),
        .rst       (rst),
        .clr       (br_taken),
        .push      (iq_push),
        .push_data (rsp_entry),
        .pop       (iq_pop),
        .head_data (iq_head),
        .count     (iq_count)
    );

    // Never flushed on redirect: stale responses still pop their own tags.
    mips32_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tagq (
        .clk       (clk1),
        .rst       (rst),
        .clr       (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .head_data (tag_head),
        .count     (tag_count)
    );

endmodule

// File: tb/tb_mips32_ifetch_queue.sv
module tb_mips32_ifetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              rst;
    logic              imem_req_valid, imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              if_id_valid, if_id_ready;
    logic [31:0]       if_id_ir, if_id_npc;
    logic              br_taken;
    logic [31:0]       br_target;
    logic              halt;

    always #5 clk1 = ~clk1;

    mips32_ifetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .PC_RESET (32'd0)
    ) dut (
        .clk1           (clk1),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_ready    (if_id_ready),
        .if_id_ir       (if_id_ir),
        .if_id_npc      (if_id_npc),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .halt           (halt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          cyc     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h1357_9BDF ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // Memory environment: fixed latency, in-order responses.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } mreq_t;
    mreq_t mq[$];
    int    lat = 1;

    // Reference model: decode sees the word at each fetched address, in fetch order,
    // except those in flight when a redirect happened.
    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;
    typedef enum {MRun, MDrain, MHalt} mmode_t;
    ent_t        m_q[$];
    logic [31:0] m_tags[$];
    logic [31:0] m_pc;
    int          m_stale;
    mmode_t      m_mode;

    // Stimulus knobs.
    int          p_rdy, p_ifr, p_br, halt_mode;
    bit          force_br;
    logic [31:0] force_tgt;
    bit          cap_first;

    function automatic logic [31:0] pick_target();
        case ($urandom_range(2))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFE;
            default: return 32'($urandom_range(1023));
        endcase
    endfunction

    task automatic step();
        bit          byp_ok, e_req, e_ifv, m_acc, m_pop;
        ent_t        e_head, tmp;
        logic [31:0] tag;
        logic [ADDR_W-1:0] ta;

        imem_rsp_valid = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mq[0].addr) : $urandom;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        if_id_ready    = ($urandom_range(99) < p_ifr);
        if (force_br) begin
            br_taken  = 1'b1;
            br_target = force_tgt;
            force_br  = 1'b0;
        end else begin
            br_taken  = !rst && ($urandom_range(99) < p_br);
            br_target = pick_target();
        end
        if (halt_mode == 2) begin
            if ($urandom_range(99) < 5) halt = !halt;
        end else begin
            halt = (halt_mode == 1);
        end

        #4;
        byp_ok = BYP && (m_q.size() == 0) && imem_rsp_valid && !br_taken && (m_stale == 0) &&
                 (m_tags.size() > 0);
        e_req  = (m_mode == MRun) && !halt && !br_taken && (m_q.size() + m_tags.size() < DEPTH);
        e_ifv  = !br_taken && ((m_q.size() > 0) || byp_ok);
        e_head = '{ir: 32'd0, npc: 32'd0};
        if (m_q.size() > 0) begin
            e_head = m_q[0];
        end else if (byp_ok) begin
            tag    = m_tags[0];
            ta     = tag[ADDR_W-1:0];
            e_head = '{ir: mem_word(ta), npc: tag + 32'd1};
        end

        if (rst) begin
            check_eq("rst_req_valid", imem_req_valid, 0);
            check_eq("rst_if_id_valid", if_id_valid, 0);
            check_eq("rst_ir", if_id_ir, 0);
            check_eq("rst_npc", if_id_npc, 0);
        end else begin
            check_eq("req_valid", imem_req_valid, e_req);
            if (e_req && imem_req_valid) check_eq("req_addr", imem_addr, m_pc[ADDR_W-1:0]);
            check_eq("if_id_valid", if_id_valid, e_ifv);
            if (e_ifv && if_id_valid) begin
                check_eq("if_id_ir", if_id_ir, e_head.ir);
                check_eq("if_id_npc", if_id_npc, e_head.npc);
            end
            if (cap_first && if_id_valid && if_id_ready) begin
                check_eq("br40_first_npc", if_id_npc, 32'd41);
                cap_first = 1'b0;
            end
        end

        // Memory environment reacts to what the DUT actually did.
        if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_addr, due: cyc + lat});
        if (imem_rsp_valid) void'(mq.pop_front());

        m_acc = e_req && imem_req_ready;
        m_pop = e_ifv && if_id_ready;
        if (rst) begin
            mq.delete();
            m_q.delete();
            m_tags.delete();
            m_pc    = 32'd0;
            m_stale = 0;
            m_mode  = MRun;
        end else if (br_taken) begin
            m_q.delete();
            if (imem_rsp_valid && m_tags.size() > 0) void'(m_tags.pop_front());
            m_stale = m_tags.size();
            m_pc    = br_target;
            if (m_mode != MHalt) m_mode = (m_stale != 0) ? MDrain : MRun;
        end else begin
            if (m_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (imem_rsp_valid && m_tags.size() > 0) begin
                tag = m_tags.pop_front();
                ta  = tag[ADDR_W-1:0];
                if (m_stale > 0) m_stale--;
                else if (!(byp_ok && m_pop)) begin
                    tmp = '{ir: mem_word(ta), npc: tag + 32'd1};
                    m_q.push_back(tmp);
                end
            end
            if (m_acc) begin
                m_tags.push_back(m_pc);
                m_pc = m_pc + 32'd1;
            end
            case (m_mode)
                MRun:    if (halt) m_mode = MHalt;
                MDrain:  if (m_stale == 0) m_mode = MRun;
                default: if (!halt) m_mode = MRun;
            endcase
        end

        @(posedge clk1);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if_id_ready = 1'b0; br_taken = 1'b0; br_target = '0; halt = 1'b0;
        m_pc = 0; m_stale = 0; m_mode = MRun;
        force_br = 0; force_tgt = 0; cap_first = 0;
        p_rdy = 100; p_ifr = 100; p_br = 0; halt_mode = 0;
        #1;

        // Streaming with latency 1, then decode stalled to exhaust credits, then released.
        lat = 1;
        do_reset(2);
        run(30);
        p_ifr = 0;
        run(15);
        p_ifr = 100;
        run(20);

        // Redirect to 40 with two requests outstanding at latency 3.
        lat = 3;
        do_reset(1);
        run(2);
        force_br = 1; force_tgt = 32'd40; cap_first = 1;
        run(16);
        check_eq("br40_seen", cap_first, 0);

        // Redirect coinciding with a response and a decode handshake.
        lat = 1;
        do_reset(1);
        run(5);
        force_br = 1; force_tgt = 32'd100;
        run(10);

        // Halt with two in flight, then resume.
        lat = 3;
        do_reset(1);
        run(2);
        halt_mode = 1;
        run(8);
        halt_mode = 0;
        run(12);

        // Redirect while halted.
        do_reset(1);
        run(2);
        halt_mode = 1;
        run(1);
        force_br = 1; force_tgt = 32'd500;
        run(8);
        halt_mode = 0;
        run(15);

        // Random mix with occasional resets.
        halt_mode = 2; p_rdy = 70; p_ifr = 60; p_br = 4;
        for (int c = 0; c < 6; c++) begin
            lat = 1 + $urandom_range(3);
            do_reset(1);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(199) == 0) rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
